// File: rtl/prm_edge_query_seq.sv
// prm_edge_query_seq: broadcasts obstacle codes to the edge-checker bank and ORs
// the checker masks of one obstacle list into a single blocked-edge bitmap.
module prm_edge_query_seq #(
    parameter int NUM_EDGE = 512,
    parameter int CHK_LAT  = 1
) (
    input  logic                CLK,
    input  logic                RST_n,
    input  logic                obs_valid,
    input  logic [14:0]         obs_code,
    input  logic                obs_last,
    output logic                obs_ready,
    output logic [14:0]         chk_query,
    input  logic [NUM_EDGE-1:0] chk_mask,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [NUM_EDGE-1:0] res_mask,
    output logic [15:0]         res_count,
    output logic                busy
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t              state_q, state_d;
    logic [CHK_LAT-1:0]  tag_valid_q, tag_last_q;
    logic [NUM_EDGE-1:0] acc_q;
    logic [15:0]         count_q;
    logic [14:0]         query_q;
    logic                accept;
    logic                exit_valid;
    logic                exit_last;
    logic                clear;

    assign obs_ready  = (state_q == IDLE) || (state_q == RUN);
    assign accept     = obs_valid && obs_ready;
    assign exit_valid = tag_valid_q[CHK_LAT-1];
    assign exit_last  = tag_valid_q[CHK_LAT-1] && tag_last_q[CHK_LAT-1];
    assign clear      = (state_q == DONE) && res_ready;

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = obs_last ? DRAIN : RUN;
            RUN:     if (accept && obs_last) state_d = DRAIN;
            DRAIN:   if (exit_last) state_d = DONE;
            DONE:    if (res_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Tags travel in step with the checker pipeline; only the oldest stage qualifies chk_mask.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            tag_valid_q <= '0;
            tag_last_q  <= '0;
        end else begin
            tag_valid_q[0] <= accept;
            tag_last_q[0]  <= accept && obs_last;
            for (int i = 1; i < CHK_LAT; i++) begin
                tag_valid_q[i] <= tag_valid_q[i-1];
                tag_last_q[i]  <= tag_last_q[i-1];
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            query_q <= '0;
            acc_q   <= '0;
            count_q <= '0;
        end else begin
            if (accept) begin
                query_q <= obs_code;
            end
            if (clear) begin
                acc_q <= '0;
            end else if (exit_valid) begin
                acc_q <= acc_q | chk_mask;
            end
            if (clear) begin
                count_q <= '0;
            end else if (accept && (count_q != 16'hFFFF)) begin
                count_q <= count_q + 16'd1;
            end
        end
    end

    assign chk_query = query_q;
    assign res_valid = (state_q == DONE);
    assign res_mask  = acc_q;
    assign res_count = count_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_prm_edge_query_seq.sv
// Bench for prm_edge_query_seq: two instances (CHK_LAT 1 and 3) fed by a checker-bank
// model; results are compared against a per-list OR/count reference.
module tb_prm_edge_query_seq;

    localparam int NE = 16;
    localparam int NI = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic          obs_valid [NI];
    logic [14:0]   obs_code  [NI];
    logic          obs_last  [NI];
    logic          obs_ready [NI];
    logic [14:0]   chk_query [NI];
    logic [NE-1:0] chk_mask  [NI];
    logic          res_valid [NI];
    logic          res_ready [NI];
    logic [NE-1:0] res_mask  [NI];
    logic [15:0]   res_count [NI];
    logic          busy      [NI];

    logic [NE-1:0] junk;
    int            tests = 0;
    int            fails = 0;
    logic [14:0]   list_codes [$];

    // Checker bank behaviour: each query maps to a fixed edge mask.
    function automatic logic [NE-1:0] mask_fn(input logic [14:0] q);
        return {1'b0, q} ^ 16'h1231;
    endfunction

    // Untagged cycles see random garbage on the mask bus.
    always @(negedge clk) junk = NE'($urandom);

    for (genvar g = 0; g < NI; g++) begin : env
        localparam int LAT = (g == 0) ? 1 : 3;
        localparam int TAP = (LAT > 1) ? LAT - 2 : 0;
        logic [14:0] q_reg [4];
        logic [3:0]  hs_reg;
        logic [14:0] tap_query;

        assign tap_query   = (LAT == 1) ? chk_query[g] : q_reg[TAP];
        assign chk_mask[g] = hs_reg[LAT-1] ? mask_fn(tap_query) : junk;

        always @(posedge clk or negedge rst_n) begin
            if (!rst_n) hs_reg <= '0;
            else        hs_reg <= {hs_reg[2:0], obs_valid[g] & obs_ready[g]};
        end

        always @(posedge clk) begin
            q_reg[0] <= chk_query[g];
            for (int i = 1; i < 4; i++) q_reg[i] <= q_reg[i-1];
        end

        prm_edge_query_seq #(.NUM_EDGE(NE), .CHK_LAT(LAT)) dut (
            .CLK       (clk),
            .RST_n     (rst_n),
            .obs_valid (obs_valid[g]),
            .obs_code  (obs_code[g]),
            .obs_last  (obs_last[g]),
            .obs_ready (obs_ready[g]),
            .chk_query (chk_query[g]),
            .chk_mask  (chk_mask[g]),
            .res_valid (res_valid[g]),
            .res_ready (res_ready[g]),
            .res_mask  (res_mask[g]),
            .res_count (res_count[g]),
            .busy      (busy[g])
        );
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests++;
        assert (observed === expected) else begin
            fails++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkResetValues(input int inst, input string tag);
        checkOutput({tag, "_query"}, 32'(chk_query[inst]), 32'h0);
        checkOutput({tag, "_mask"},  32'(res_mask[inst]),  32'h0);
        checkOutput({tag, "_count"}, 32'(res_count[inst]), 32'h0);
        checkOutput({tag, "_valid"}, 32'(res_valid[inst]), 32'h0);
        checkOutput({tag, "_busy"},  32'(busy[inst]),      32'h0);
        checkOutput({tag, "_ready"}, 32'(obs_ready[inst]), 32'h1);
    endtask

    // Sends list_codes to one instance, optionally with random bubbles; returns at the
    // falling edge after the final code was accepted.
    task automatic applyStimulus(input int inst, input bit gapped, input string tag);
        int i;
        int guard;
        int limit;
        i = 0;
        guard = 0;
        limit = 4 * list_codes.size() + 50;
        while (i < list_codes.size() && guard < limit) begin
            if (gapped && ($urandom_range(0, 1) == 1)) begin
                obs_valid[inst] = 1'b0;
                obs_code[inst]  = 15'($urandom);
                obs_last[inst]  = 1'($urandom);
            end else begin
                obs_valid[inst] = 1'b1;
                obs_code[inst]  = list_codes[i];
                obs_last[inst]  = (i == list_codes.size() - 1);
            end
            if (obs_valid[inst] && obs_ready[inst]) i++;
            @(negedge clk);
            guard++;
        end
        obs_valid[inst] = 1'b0;
        obs_last[inst]  = 1'b0;
        checkOutput({tag, "_sent"}, 32'(i), 32'(list_codes.size()));
    endtask

    task automatic waitResult(input int inst, input int lat, input string tag);
        int cycles;
        cycles = 0;
        while (!res_valid[inst] && cycles < 20) begin
            checkOutput({tag, "_drain_ready"}, 32'(obs_ready[inst]), 32'h0);
            checkOutput({tag, "_drain_busy"},  32'(busy[inst]),      32'h1);
            @(negedge clk);
            cycles++;
        end
        checkOutput({tag, "_latency"}, 32'(cycles), 32'(lat));
    endtask

    // Checks the result, holds it under backpressure for 'hold' cycles, then hands it off.
    task automatic checkResult(input int inst, input string tag, input logic [NE-1:0] exp_mask,
                               input logic [15:0] exp_count, input int hold);
        checkOutput({tag, "_valid"}, 32'(res_valid[inst]), 32'h1);
        checkOutput({tag, "_mask"},  32'(res_mask[inst]),  32'(exp_mask));
        checkOutput({tag, "_count"}, 32'(res_count[inst]), 32'(exp_count));
        checkOutput({tag, "_done_ready"}, 32'(obs_ready[inst]), 32'h0);
        for (int c = 0; c < hold; c++) begin
            res_ready[inst] = 1'b0;
            obs_valid[inst] = 1'b1;
            obs_code[inst]  = 15'($urandom);
            @(negedge clk);
            checkOutput({tag, "_hold_valid"}, 32'(res_valid[inst]), 32'h1);
            checkOutput({tag, "_hold_mask"},  32'(res_mask[inst]),  32'(exp_mask));
            checkOutput({tag, "_hold_count"}, 32'(res_count[inst]), 32'(exp_count));
            checkOutput({tag, "_hold_ready"}, 32'(obs_ready[inst]), 32'h0);
        end
        obs_valid[inst] = 1'b0;
        res_ready[inst] = 1'b1;
        @(negedge clk);
        res_ready[inst] = 1'b0;
        checkOutput({tag, "_after_valid"}, 32'(res_valid[inst]), 32'h0);
        checkOutput({tag, "_after_busy"},  32'(busy[inst]),      32'h0);
        checkOutput({tag, "_after_ready"}, 32'(obs_ready[inst]), 32'h1);
        checkOutput({tag, "_after_count"}, 32'(res_count[inst]), 32'h0);
    endtask

    task automatic runList(input int inst, input bit gapped, input int hold, input string tag);
        logic [NE-1:0] exp_mask;
        logic [15:0]   exp_count;
        exp_mask = '0;
        foreach (list_codes[k]) exp_mask |= mask_fn(list_codes[k]);
        exp_count = (list_codes.size() > 65535) ? 16'hFFFF : 16'(list_codes.size());
        applyStimulus(inst, gapped, tag);
        waitResult(inst, (inst == 0) ? 1 : 3, tag);
        checkResult(inst, tag, exp_mask, exp_count, hold);
    endtask

    initial begin
        for (int k = 0; k < NI; k++) begin
            obs_valid[k] = 1'b0;
            obs_code[k]  = '0;
            obs_last[k]  = 1'b0;
            res_ready[k] = 1'b0;
        end
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checkResetValues(0, "rst_in0");
        checkResetValues(1, "rst_in1");
        rst_n = 1'b1;
        @(negedge clk);
        checkResetValues(0, "rst_out0");
        checkResetValues(1, "rst_out1");

        // Single-code list with the consumer already ready.
        list_codes.delete();
        list_codes.push_back(15'h1234);
        res_ready[0] = 1'b1;
        runList(0, 1'b0, 0, "single");

        // Three back-to-back codes through the deeper pipeline.
        list_codes.delete();
        list_codes.push_back(15'h1230);
        list_codes.push_back(15'h1233);
        list_codes.push_back(15'h1239);
        runList(1, 1'b0, 0, "three");

        // Gapped streams on both instances, junk on the mask bus during bubbles.
        for (int inst = 0; inst < NI; inst++) begin
            list_codes.delete();
            for (int k = 0; k < 6; k++) list_codes.push_back(15'h1231 ^ 15'($urandom_range(0, 255)));
            runList(inst, 1'b1, 0, "gapped");
        end

        // Backpressure, then a disjoint list must not inherit the old bits.
        list_codes.delete();
        list_codes.push_back(15'h1239);
        runList(1, 1'b0, 10, "bp_first");
        list_codes.delete();
        list_codes.push_back(15'h1230);
        runList(1, 1'b0, 0, "bp_second");

        // Reset pulse with two tags in flight.
        obs_valid[1] = 1'b1;
        obs_last[1]  = 1'b0;
        obs_code[1]  = 15'h1233;
        @(negedge clk);
        obs_code[1]  = 15'h1239;
        @(negedge clk);
        obs_valid[1] = 1'b0;
        checkOutput("rst_mid_busy",  32'(busy[1]),      32'h1);
        checkOutput("rst_mid_count", 32'(res_count[1]), 32'h2);
        #2 rst_n = 1'b0;
        #1 checkResetValues(1, "rst_mid");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        list_codes.delete();
        list_codes.push_back(15'h1234);
        runList(1, 1'b0, 0, "post_rst");

        // Random lists on both instances.
        for (int r = 0; r < 8; r++) begin
            list_codes.delete();
            for (int k = 0; k < $urandom_range(1, 8); k++) list_codes.push_back(15'($urandom));
            runList(r % NI, 1'($urandom), $urandom_range(0, 3), "rand");
        end

        // Count saturation; the final code alone sets bit 14.
        list_codes.delete();
        for (int k = 0; k < 65536; k++) list_codes.push_back(15'h1231 ^ 15'($urandom_range(0, 255)));
        list_codes.push_back(15'h1231 ^ 15'h4000);
        runList(0, 1'b0, 0, "sat");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/prm_edge_query_seq.md
# prm_edge_query_seq

Streams a list of 15-bit obstacle codes into the bank of `prm_oblgc_chk*` edge checkers and accumulates their `edge_mask` outputs into one blocked-edge bitmap per list. It sits between the obstacle-voxel source and the PRM graph-update logic. The query is broadcast to every checker; bit k of the result is set if edge k is hit by any obstacle in the list. The result is handed downstream over a valid/ready handshake.

## Interface
Parameters:
- `NUM_EDGE`, default 512: number of checker instances, and the width of the mask bus.
- `CHK_LAT`, default 1, legal range 1..4: clock edges from `chk_query` loading to `chk_mask` being sampled for that query.

Ports (name, direction, width, meaning):
- `CLK` in 1: the single clock; all state changes on the rising edge.
- `RST_n` in 1: reset, asynchronous and active-low.
- `obs_valid` in 1: an obstacle code is presented.
- `obs_code` in 15: obstacle code; bit 0 drives checker input A, bit 14 drives input O.
- `obs_last` in 1: marks the final code of a list; qualified by `obs_valid`.
- `obs_ready` out 1: the block accepts a code this cycle.
- `chk_query` out 15: registered query, broadcast to all checkers.
- `chk_mask` in `NUM_EDGE`: concatenated checker `edge_mask` outputs; bit k comes from checker k.
- `res_valid` out 1: `res_mask` and `res_count` are valid.
- `res_ready` in 1: the consumer accepts the result.
- `res_mask` out `NUM_EDGE`: OR of all checker masks for the list.
- `res_count` out 16: number of codes accepted in the list, saturating at 16'hFFFF.
- `busy` out 1: high whenever the state is not IDLE.

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE. Reset state is IDLE.
- A code is accepted when `obs_valid & obs_ready`.
- `obs_ready` = 1 in IDLE and RUN, and 0 in DRAIN and DONE.
- On accept:
  - `chk_query <= obs_code`.
  - A tag {valid, last} is pushed into a `CHK_LAT`-deep shift register.
  - `res_count` increments, but holds at 16'hFFFF once saturated.
- State transitions:
  - IDLE -> RUN on an accept with `obs_last=0`.
  - IDLE -> DRAIN on an accept with `obs_last=1`.
  - RUN -> DRAIN on an accept with `obs_last=1`.
- Tag exit: when a tag with valid=1 leaves the shift register, `acc <= acc | chk_mask`.
- DRAIN -> DONE when the tag with last=1 exits. The final OR is applied on that same edge.
- DONE:
  - `res_valid=1`; `res_mask=acc`.
  - `res_mask` and `res_count` are stable while `res_valid & !res_ready`.
- DONE -> IDLE on `res_ready`. On that edge, `acc` and `res_count` clear to 0.
- A list of one code is legal and goes IDLE -> DRAIN directly. Every list terminates with `obs_last`; there is no empty list.
- `chk_query` holds its last value when no code is accepted. Checkers are combinational, so stale queries are harmless: untagged masks are never ORed into `acc`.
- Gaps in `obs_valid` during RUN are allowed. Only tagged stages contribute to `acc`.
- `obs_last` with `obs_valid=0` is ignored.

## Timing
- Reset values (while `RST_n`=0 and after release):
  - `chk_query`=0, `res_mask`=0, `res_count`=0.
  - `res_valid`=0, `busy`=0, `obs_ready`=1.
  - All tags are invalid.
- Throughput: one code per cycle in IDLE/RUN.
- Latency: if `obs_last` is accepted on edge t, `res_valid` rises on edge t+`CHK_LAT`.
- Minimum list period: list length + `CHK_LAT` + 1 cycles, with `res_ready` held high.
- The result holds indefinitely under backpressure. No new code is accepted until the DONE -> IDLE edge.
- Reset asserted mid-list or during DONE takes effect immediately:
  - in-flight tags are discarded;
  - `acc` and the count are cleared;
  - any pending result is lost.
- `res_count` saturation: the 65536th accept and all later accepts leave the count at 16'hFFFF. The mask keeps accumulating.

## Test plan
- Single-code list, `CHK_LAT`=1, `chk_mask`=0x5 for code 0x1234, `res_ready`=1:
  - `res_valid` high exactly one edge after accept;
  - `res_mask`=0x5, `res_count`=1.
- Three back-to-back codes producing masks 0x1, 0x2, 0x8; `CHK_LAT`=3:
  - `res_mask`=0xB, `res_count`=3;
  - `obs_ready` is low for exactly 3 cycles of DRAIN plus the DONE cycle.
- Gapped stream (`obs_valid` toggling), with nonzero `chk_mask` driven during gaps:
  - gap masks never appear in `res_mask`.
- Backpressure: `res_ready`=0 for 10 cycles in DONE.
  - `res_valid` stays high, and `res_mask`/`res_count` stay constant;
  - `obs_ready`=0 throughout;
  - after the handshake, the next list's result does not include the old bits.
- `RST_n` pulsed low mid-list with 2 tags in flight:
  - all outputs take their reset values asynchronously;
  - a subsequent single-code list reports only its own mask and `res_count`=1.
